ac_motor_bridge_guard: RTL and testbench

//  Last stage before the three-phase inverter gate pins. Takes high/low-side requests from three

---
 rtl/ac_motor_bridge_guard_pkg.sv | 16 +
 rtl/ac_motor_bridge_guard_leg.sv | 74 +++++++
 rtl/ac_motor_bridge_guard.sv | 161 ++++++++++++++++
 tb/tb_ac_motor_bridge_guard.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ac_motor_bridge_guard_pkg.sv
// Shared definitions for the three-phase bridge guard: FSM state encoding and phase indices.
package ac_motor_bridge_guard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_FAULT    = 2'd2,
        ST_COOLDOWN = 2'd3
    } bridge_state_e;

    localparam int NUM_PHASES = 3;
    localparam int PH_U       = 0;
    localparam int PH_V       = 1;
    localparam int PH_W       = 2;

endpackage

// File: rtl/ac_motor_bridge_guard_leg.sv
// One inverter leg: request registers, per-gate stability counters, hi/lo interlock, gate registers.
module ac_motor_bridge_leg #(
    parameter int MIN_PULSE = 50
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_run_en,
    input  logic i_hi_req,
    input  logic i_lo_req,
    output logic o_gate_hi,
    output logic o_gate_lo,
    output logic o_ilk_err
);

    localparam int             CW      = $clog2(MIN_PULSE + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MIN_PULSE);
    localparam logic [CW-1:0]  CNT_ON  = CW'(MIN_PULSE - 1);

    logic          r_hi_req;
    logic          r_lo_req;
    logic [CW-1:0] r_hi_cnt;
    logic [CW-1:0] r_lo_cnt;
    logic          r_gate_hi;
    logic          r_gate_lo;
    logic          r_ilk_err;

    logic          w_ilk;
    logic          w_hi_ok;
    logic          w_lo_ok;
    logic [CW-1:0] w_hi_cnt_nxt;
    logic [CW-1:0] w_lo_cnt_nxt;

    // Counters only run while the bridge is enabled and the leg is not in conflict,
    // so every re-entry to RUN starts the stability window from zero.
    always_comb begin
        w_ilk        = r_hi_req & r_lo_req;
        w_hi_ok      = i_run_en & ~w_ilk & r_hi_req;
        w_lo_ok      = i_run_en & ~w_ilk & r_lo_req;
        w_hi_cnt_nxt = '0;
        w_lo_cnt_nxt = '0;
        if (w_hi_ok) begin
            w_hi_cnt_nxt = (r_hi_cnt == CNT_MAX) ? r_hi_cnt : r_hi_cnt + 1'b1;
        end
        if (w_lo_ok) begin
            w_lo_cnt_nxt = (r_lo_cnt == CNT_MAX) ? r_lo_cnt : r_lo_cnt + 1'b1;
        end
    end

    // The live request also qualifies the gate so it drops one cycle after the request falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi_req  <= 1'b0;
            r_lo_req  <= 1'b0;
            r_hi_cnt  <= '0;
            r_lo_cnt  <= '0;
            r_gate_hi <= 1'b0;
            r_gate_lo <= 1'b0;
            r_ilk_err <= 1'b0;
        end else begin
            r_hi_req  <= i_hi_req;
            r_lo_req  <= i_lo_req;
            r_hi_cnt  <= w_hi_cnt_nxt;
            r_lo_cnt  <= w_lo_cnt_nxt;
            r_gate_hi <= w_hi_ok & i_hi_req & (r_hi_cnt >= CNT_ON);
            r_gate_lo <= w_lo_ok & i_lo_req & (r_lo_cnt >= CNT_ON);
            r_ilk_err <= r_ilk_err | w_ilk;
        end
    end

    assign o_gate_hi = r_gate_hi;
    assign o_gate_lo = r_gate_lo;
    assign o_ilk_err = r_ilk_err;

endmodule

// File: rtl/ac_motor_bridge_guard.sv
// Bridge guard top: fault synchronizer/filter, run/stop FSM, three guarded legs.
// Build option AC_MOTOR_BRIDGE_GUARD_AUTO_RETRY_EN enables timed automatic retry after a fault.
module ac_motor_bridge_guard
    import ac_motor_bridge_guard_pkg::*;
#(
    parameter int MIN_PULSE    = 50,
    parameter int FAULT_FILTER = 8,
    parameter int RETRY_CYCLES = 5000,
    parameter int MAX_RETRY    = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  arm,
    input  logic                  clear,
    input  logic                  fault_n,
    input  logic [NUM_PHASES-1:0] hi_req,
    input  logic [NUM_PHASES-1:0] lo_req,
    output logic [NUM_PHASES-1:0] gate_hi,
    output logic [NUM_PHASES-1:0] gate_lo,
    output logic                  fault,
    output logic                  interlock_err,
    output logic [1:0]            state
);

    localparam int            FW      = $clog2(FAULT_FILTER + 1);
    localparam logic [FW-1:0] FLT_MAX = FW'(FAULT_FILTER);

    logic                  r_fault_meta;
    logic                  r_fault_sync;
    logic [FW-1:0]         r_flt_cnt;
    bridge_state_e         r_state;
    bridge_state_e         w_state_nxt;
    logic                  w_fault_det;
    logic                  w_run_en;
    logic [NUM_PHASES-1:0] w_ilk_err;

    // Synchronizer resets to the inactive (high) level of fault_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fault_meta <= 1'b1;
            r_fault_sync <= 1'b1;
            r_flt_cnt    <= '0;
        end else begin
            r_fault_meta <= fault_n;
            r_fault_sync <= r_fault_meta;
            if (r_fault_sync) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt != FLT_MAX) begin
                r_flt_cnt <= r_flt_cnt + 1'b1;
            end
        end
    end

    assign w_fault_det = (r_flt_cnt == FLT_MAX);

`ifdef AC_MOTOR_BRIDGE_GUARD_AUTO_RETRY_EN
    localparam int             RW       = $clog2(MAX_RETRY + 1);
    localparam int             CCW      = $clog2(RETRY_CYCLES + 1);
    localparam logic [CCW-1:0] COOL_END = CCW'(RETRY_CYCLES - 1);
    localparam logic [CCW-1:0] COOL_MAX = CCW'(RETRY_CYCLES);

    logic [RW-1:0]  r_retry_cnt;
    logic [CCW-1:0] r_cool_cnt;
    logic           w_retry_inc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_retry_cnt <= '0;
            r_cool_cnt  <= '0;
        end else begin
            if (clear) begin
                r_retry_cnt <= '0;
            end else if (w_retry_inc) begin
                r_retry_cnt <= r_retry_cnt + 1'b1;
            end
            if (r_state != ST_COOLDOWN) begin
                r_cool_cnt <= '0;
            end else if (r_cool_cnt != COOL_MAX) begin
                r_cool_cnt <= r_cool_cnt + 1'b1;
            end
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{RETRY_CYCLES[0], MAX_RETRY[0]};
`endif

    always_comb begin
        w_state_nxt = r_state;
`ifdef AC_MOTOR_BRIDGE_GUARD_AUTO_RETRY_EN
        w_retry_inc = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (arm) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!arm) w_state_nxt = ST_IDLE;
            end
            ST_FAULT: begin
                if (!w_fault_det) begin
                    if (clear) begin
                        w_state_nxt = ST_IDLE;
                    end
`ifdef AC_MOTOR_BRIDGE_GUARD_AUTO_RETRY_EN
                    else if (r_retry_cnt < RW'(MAX_RETRY)) begin
                        w_state_nxt = ST_COOLDOWN;
                        w_retry_inc = 1'b1;
                    end
`endif
                end
            end
            ST_COOLDOWN: begin
`ifdef AC_MOTOR_BRIDGE_GUARD_AUTO_RETRY_EN
                if (!arm) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cool_cnt == COOL_END) begin
                    w_state_nxt = ST_RUN;
                end
`else
                w_state_nxt = ST_IDLE;
`endif
            end
        endcase
        // A detected fault overrides every other transition, including a coincident clear.
        if (w_fault_det) begin
            w_state_nxt = ST_FAULT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Legs see the upcoming state so gates drop on the same edge the FSM leaves RUN.
    assign w_run_en = (w_state_nxt == ST_RUN);

    for (genvar g = 0; g < NUM_PHASES; g++) begin : g_leg
        ac_motor_bridge_leg #(
            .MIN_PULSE (MIN_PULSE)
        ) u_leg (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_run_en  (w_run_en),
            .i_hi_req  (hi_req[g]),
            .i_lo_req  (lo_req[g]),
            .o_gate_hi (gate_hi[g]),
            .o_gate_lo (gate_lo[g]),
            .o_ilk_err (w_ilk_err[g])
        );
    end

    assign interlock_err = |w_ilk_err;
    assign fault         = (r_state == ST_FAULT) || (r_state == ST_COOLDOWN);
    assign state         = r_state;

endmodule

// File: tb/tb_ac_motor_bridge_guard.sv
// Directed bench for ac_motor_bridge_guard: gate timing, glitch rejection, interlock, fault path, FSM.
module tb_ac_motor_bridge_guard;
    import ac_motor_bridge_guard_pkg::*;

`ifdef AC_MOTOR_BRIDGE_GUARD_AUTO_RETRY_EN
    localparam int TB_RETRY = 100;
`else
    localparam int TB_RETRY = 5000;
`endif

    logic       clk;
    logic       reset_n;
    logic       arm;
    logic       clear;
    logic       fault_n;
    logic [2:0] hi_req;
    logic [2:0] lo_req;
    logic [2:0] gate_hi;
    logic [2:0] gate_lo;
    logic       fault;
    logic       interlock_err;
    logic [1:0] state;

    int n_checks;
    int n_errors;

    ac_motor_bridge_guard #(
        .MIN_PULSE    (50),
        .FAULT_FILTER (8),
        .RETRY_CYCLES (TB_RETRY),
        .MAX_RETRY    (3)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .arm           (arm),
        .clear         (clear),
        .fault_n       (fault_n),
        .hi_req        (hi_req),
        .lo_req        (lo_req),
        .gate_hi       (gate_hi),
        .gate_lo       (gate_lo),
        .fault         (fault),
        .interlock_err (interlock_err),
        .state         (state)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; arm = 1'b0; clear = 1'b0; fault_n = 1'b1;
        hi_req = 3'b000; lo_req = 3'b000;
        #1;
        n_checks++;
        if ({gate_hi, gate_lo, fault, interlock_err, state} !== 10'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b expected 0", {gate_hi, gate_lo, fault, interlock_err, state});
        end
        tick(3);
        reset_n = 1'b1;
        tick(2);
        n_checks++;
        if (state !== 2'd0) begin
            n_errors++;
            $display("FAIL idle_after_reset: state=%0d expected 0", state);
        end
        arm = 1'b1;
        tick(1);
        n_checks++;
        if (state !== 2'd1) begin
            n_errors++;
            $display("FAIL arm_to_run: state=%0d expected 1", state);
        end
    endtask

    task automatic test_pulse_on();
        hi_req[PH_U] = 1'b1;
        tick(50);
        n_checks++;
        if (gate_hi[PH_U] !== 1'b0) begin
            n_errors++;
            $display("FAIL gate_early_cyc50: gate_hi[0]=%b expected 0", gate_hi[PH_U]);
        end
        tick(1);
        n_checks++;
        if (gate_hi[PH_U] !== 1'b1) begin
            n_errors++;
            $display("FAIL gate_rise_cyc51: gate_hi[0]=%b expected 1", gate_hi[PH_U]);
        end
        tick(149);
        n_checks++;
        if (gate_hi[PH_U] !== 1'b1 || gate_lo !== 3'b000) begin
            n_errors++;
            $display("FAIL gate_hold: gate_hi=%b gate_lo=%b expected 001/000", gate_hi, gate_lo);
        end
        hi_req[PH_U] = 1'b0;
        tick(1);
        n_checks++;
        if (gate_hi[PH_U] !== 1'b0) begin
            n_errors++;
            $display("FAIL gate_fall: gate_hi[0]=%b expected 0", gate_hi[PH_U]);
        end
    endtask

    task automatic test_short_pulse();
        logic seen;
        seen = 1'b0;
        hi_req[PH_V] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            seen |= gate_hi[PH_V];
        end
        hi_req[PH_V] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            seen |= gate_hi[PH_V];
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_errors++;
            $display("FAIL short_pulse: gate_hi[1] seen=%b expected 0", seen);
        end
    endtask

    task automatic test_interlock();
        hi_req[PH_W] = 1'b1;
        tick(60);
        n_checks++;
        if (gate_hi[PH_W] !== 1'b1 || interlock_err !== 1'b0) begin
            n_errors++;
            $display("FAIL ilk_pre: gate_hi[2]=%b err=%b expected 1/0", gate_hi[PH_W], interlock_err);
        end
        lo_req[PH_W] = 1'b1;
        tick(1);
        lo_req[PH_W] = 1'b0;
        tick(1);
        n_checks++;
        if (gate_hi[PH_W] !== 1'b0 || gate_lo[PH_W] !== 1'b0 || interlock_err !== 1'b1 || state !== 2'd1) begin
            n_errors++;
            $display("FAIL ilk_trip: hi=%b lo=%b err=%b state=%0d expected 0/0/1/1",
                     gate_hi[PH_W], gate_lo[PH_W], interlock_err, state);
        end
        hi_req[PH_W] = 1'b0;
        tick(10);
        n_checks++;
        if (interlock_err !== 1'b1 || state !== 2'd1) begin
            n_errors++;
            $display("FAIL ilk_sticky: err=%b state=%0d expected 1/1", interlock_err, state);
        end
    endtask

    task automatic test_fault_filter();
        hi_req[PH_U] = 1'b1;
        tick(60);
        n_checks++;
        if (gate_hi[PH_U] !== 1'b1) begin
            n_errors++;
            $display("FAIL flt_pre: gate_hi[0]=%b expected 1", gate_hi[PH_U]);
        end
        fault_n = 1'b0;
        tick(7);
        fault_n = 1'b1;
        tick(15);
        n_checks++;
        if (fault !== 1'b0 || state !== 2'd1 || gate_hi[PH_U] !== 1'b1) begin
            n_errors++;
            $display("FAIL flt_7low: fault=%b state=%0d gate=%b expected 0/1/1", fault, state, gate_hi[PH_U]);
        end
        fault_n = 1'b0;
        tick(10);
        n_checks++;
        if (fault !== 1'b0 || gate_hi[PH_U] !== 1'b1) begin
            n_errors++;
            $display("FAIL flt_cyc10: fault=%b gate=%b expected 0/1", fault, gate_hi[PH_U]);
        end
        tick(1);
        n_checks++;
        if (fault !== 1'b1 || gate_hi !== 3'b000 || gate_lo !== 3'b000 || state !== 2'd2) begin
            n_errors++;
            $display("FAIL flt_cyc11: fault=%b hi=%b lo=%b state=%0d expected 1/000/000/2",
                     fault, gate_hi, gate_lo, state);
        end
    endtask

    task automatic test_fault_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        n_checks++;
        if (state !== 2'd2 || fault !== 1'b1) begin
            n_errors++;
            $display("FAIL clear_while_low: state=%0d fault=%b expected 2/1", state, fault);
        end
        tick(3);
        arm = 1'b0;
        fault_n = 1'b1;
        tick(10);
`ifndef AC_MOTOR_BRIDGE_GUARD_AUTO_RETRY_EN
        n_checks++;
        if (state !== 2'd2) begin
            n_errors++;
            $display("FAIL fault_latched: state=%0d expected 2", state);
        end
`endif
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        n_checks++;
        if (state !== 2'd0 || fault !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_to_idle: state=%0d fault=%b expected 0/0", state, fault);
        end
        arm = 1'b1;
        tick(1);
        n_checks++;
        if (state !== 2'd1 || gate_hi[PH_U] !== 1'b0) begin
            n_errors++;
            $display("FAIL rearm_run: state=%0d gate=%b expected 1/0", state, gate_hi[PH_U]);
        end
        tick(60);
        n_checks++;
        if (gate_hi[PH_U] !== 1'b1) begin
            n_errors++;
            $display("FAIL rearm_gate: gate_hi[0]=%b expected 1", gate_hi[PH_U]);
        end
    endtask

    task automatic test_arm_drop();
        arm = 1'b0;
        tick(1);
        n_checks++;
        if (state !== 2'd0 || gate_hi !== 3'b000) begin
            n_errors++;
            $display("FAIL arm_drop: state=%0d gate_hi=%b expected 0/000", state, gate_hi);
        end
        arm = 1'b1;
        tick(1);
        n_checks++;
        if (state !== 2'd1) begin
            n_errors++;
            $display("FAIL arm_again: state=%0d expected 1", state);
        end
    endtask

`ifdef AC_MOTOR_BRIDGE_GUARD_AUTO_RETRY_EN
    task automatic test_auto_retry();
        for (int r = 0; r < 4; r++) begin
            int cool_at;
            int run_at;
            cool_at = -1;
            run_at  = -1;
            fault_n = 1'b0;
            tick(8);
            fault_n = 1'b1;
            for (int c = 0; c < 400; c++) begin
                tick(1);
                if (state == 2'd3 && cool_at < 0) cool_at = c;
                if (state == 2'd1 && cool_at >= 0) begin
                    run_at = c;
                    break;
                end
            end
            n_checks++;
            if (r < 3) begin
                if (cool_at < 0 || run_at - cool_at != 100) begin
                    n_errors++;
                    $display("FAIL retry_%0d: cooldown_at=%0d run_at=%0d expected 100 apart", r, cool_at, run_at);
                end
            end else if (cool_at >= 0 || state !== 2'd2) begin
                n_errors++;
                $display("FAIL retry_limit: cooldown_at=%0d state=%0d expected -1/2", cool_at, state);
            end
        end
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        n_checks++;
        if (state !== 2'd0) begin
            n_errors++;
            $display("FAIL retry_clear: state=%0d expected 0", state);
        end
        tick(1);
    endtask
`endif

    task automatic test_async_reset();
        hi_req[PH_U] = 1'b1;
        tick(60);
        n_checks++;
        if (gate_hi[PH_U] !== 1'b1) begin
            n_errors++;
            $display("FAIL areset_pre: gate_hi[0]=%b expected 1", gate_hi[PH_U]);
        end
        #3 reset_n = 1'b0;
        #1;
        n_checks++;
        if (gate_hi !== 3'b000 || interlock_err !== 1'b0 || state !== 2'd0) begin
            n_errors++;
            $display("FAIL areset_mid: hi=%b err=%b state=%0d expected 000/0/0", gate_hi, interlock_err, state);
        end
        hi_req = 3'b000;
        tick(2);
        reset_n = 1'b1;
        tick(2);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_pulse_on();
        test_short_pulse();
        test_interlock();
        test_fault_filter();
        test_fault_clear();
        test_arm_drop();
`ifdef AC_MOTOR_BRIDGE_GUARD_AUTO_RETRY_EN
        test_auto_retry();
`endif
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
